// File: rtl/bridge_pkg.sv
// Shared types, IDs and helpers for the SRAM-like to AXI3 bridge.
package bridge_pkg;

    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_B}   w_state_t;

    localparam logic [3:0] ARID_INST  = 4'd0;
    localparam logic [3:0] ARID_DATA  = 4'd1;
    localparam logic [3:0] AWID       = 4'd1;
    localparam logic [1:0] BURST_INCR = 2'b01;

    function automatic logic [2:0] axi_size(input logic [1:0] size);
        return {1'b0, size};
    endfunction

endpackage

// File: rtl/axi_wr_ctrl.sv
// Single-outstanding AXI3 write engine; AW and W handshakes are tracked
// independently so the slave may accept them in either order.
module axi_wr_ctrl
    import bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              accept,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic [3:0]        req_wstrb,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              idle,
    output logic [ADDR_W-1:0] awaddr,
    output logic [2:0]        awsize,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic [3:0]        wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic              bvalid,
    output logic              bready,
    output logic              b_done
);

    w_state_t   state, state_next;
    logic       aw_done, w_done;
    logic       aw_hs, w_hs;
    logic [1:0] size_q;

    assign aw_hs   = awvalid & awready;
    assign w_hs    = wvalid & wready;
    assign idle    = (state == W_IDLE);
    assign awvalid = (state == W_REQ) & ~aw_done;
    assign wvalid  = (state == W_REQ) & ~w_done;
    assign bready  = (state == W_B);
    assign b_done  = bready & bvalid;
    assign awsize  = axi_size(size_q);

    // NOTE: state registers use non-blocking assignments; the next-state block is blocking with a default first so no latch is inferred.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= W_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            W_IDLE:  if (accept) state_next = W_REQ;
            W_REQ:   if ((aw_done | aw_hs) & (w_done | w_hs)) state_next = W_B;
            W_B:     if (bvalid) state_next = W_IDLE;
            default: state_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            awaddr  <= '0;
            size_q  <= '0;
            wdata   <= '0;
            wstrb   <= '0;
        end else if (accept) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            awaddr  <= req_addr;
            size_q  <= req_size;
            wdata   <= req_wdata;
            wstrb   <= req_wstrb;
        end else if (state == W_REQ) begin
            aw_done <= aw_done | aw_hs;
            w_done  <= w_done | w_hs;
        end
    end

endmodule

// File: rtl/sram_axi_bridge.sv
// Bridges the core's instruction and data SRAM-like ports onto one AXI3 master
// with one outstanding read and one outstanding write, hazard-free ordering.
module sram_axi_bridge
    import bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_req,
    output logic              inst_addr_ok,
    input  logic [1:0]        inst_size,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    output logic              data_addr_ok,
    input  logic [1:0]        data_size,
    input  logic [3:0]        data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic [3:0]        arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [2:0]        arsize,
    output logic [3:0]        arlen,
    output logic [1:0]        arburst,
    output logic [1:0]        arlock,
    output logic [3:0]        arcache,
    output logic [2:0]        arprot,
    output logic              arvalid,
    input  logic              arready,
    input  logic [3:0]        rid,
    input  logic [DATA_W-1:0] rdata,
    input  logic              rvalid,
    output logic              rready,
    output logic [3:0]        awid,
    output logic [ADDR_W-1:0] awaddr,
    output logic [2:0]        awsize,
    output logic [3:0]        awlen,
    output logic [1:0]        awburst,
    output logic [1:0]        awlock,
    output logic [3:0]        awcache,
    output logic [2:0]        awprot,
    output logic              awvalid,
    input  logic              awready,
    output logic [3:0]        wid,
    output logic [DATA_W-1:0] wdata,
    output logic [3:0]        wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    input  logic              bvalid,
    output logic              bready
);

    r_state_t          r_state, r_next;
    logic [3:0]        r_id;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic              r_idle, r_hs;
    logic              w_idle, b_done;
    logic              data_rd_ok, data_wr_ok;
    logic              inst_ok_q, data_ok_q;
    logic [DATA_W-1:0] rdata_q;
    logic              unused_rid;

    // Single outstanding read, so the returned ID carries no information.
    assign unused_rid = ^rid;

    assign arlen   = 4'd0;
    assign arburst = BURST_INCR;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign awid    = AWID;
    assign awlen   = 4'd0;
    assign awburst = BURST_INCR;
    assign awlock  = 2'b00;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign wid     = AWID;
    assign wlast   = 1'b1;

    // A data read waits for an idle write path; a write waits out any data read.
    assign r_idle       = (r_state == R_IDLE);
    assign data_rd_ok   = data_req & ~data_wr & w_idle & r_idle;
    assign data_wr_ok   = data_req & data_wr & w_idle & (r_idle | (r_id == ARID_INST));
    assign data_addr_ok = data_rd_ok | data_wr_ok;
    assign inst_addr_ok = inst_req & ~data_rd_ok & r_idle;

    assign arvalid = (r_state == R_AR);
    assign rready  = (r_state == R_DATA);
    assign r_hs    = rready & rvalid;
    assign arid    = r_id;
    assign araddr  = r_addr;
    assign arsize  = axi_size(r_size);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= R_IDLE;
        else       r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (data_rd_ok | inst_addr_ok) r_next = R_AR;
            R_AR:    if (arready) r_next = R_DATA;
            R_DATA:  if (rvalid) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_id   <= ARID_INST;
            r_addr <= '0;
            r_size <= '0;
        end else if (data_rd_ok) begin
            r_id   <= ARID_DATA;
            r_addr <= data_addr;
            r_size <= data_size;
        end else if (inst_addr_ok) begin
            r_id   <= ARID_INST;
            r_addr <= inst_addr;
            r_size <= inst_size;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inst_ok_q <= 1'b0;
            data_ok_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            inst_ok_q <= r_hs & (r_id == ARID_INST);
            data_ok_q <= (r_hs & (r_id == ARID_DATA)) | b_done;
            if (r_hs) rdata_q <= rdata;
        end
    end

    assign inst_data_ok = inst_ok_q;
    assign data_data_ok = data_ok_q;
    assign inst_rdata   = rdata_q;
    assign data_rdata   = rdata_q;

    axi_wr_ctrl #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_wr (
        .clk      (clk),
        .reset    (reset),
        .accept   (data_wr_ok),
        .req_addr (data_addr),
        .req_size (data_size),
        .req_wstrb(data_wstrb),
        .req_wdata(data_wdata),
        .idle     (w_idle),
        .awaddr   (awaddr),
        .awsize   (awsize),
        .awvalid  (awvalid),
        .awready  (awready),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .wvalid   (wvalid),
        .wready   (wready),
        .bvalid   (bvalid),
        .bready   (bready),
        .b_done   (b_done)
    );

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge with a latency-programmable AXI3 slave.
module tb_sram_axi_bridge;

    logic        clk, reset;
    logic        inst_req, inst_addr_ok, inst_data_ok;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  arid, arlen, arcache;
    logic [31:0] araddr;
    logic [2:0]  arsize, arprot;
    logic [1:0]  arburst, arlock;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic        rvalid, rready;
    logic [3:0]  awid, awlen, awcache;
    logic [31:0] awaddr;
    logic [2:0]  awsize, awprot;
    logic [1:0]  awburst, awlock;
    logic        awvalid, awready;
    logic [3:0]  wid, wstrb;
    logic [31:0] wdata;
    logic        wlast, wvalid, wready;
    logic        bvalid, bready;

    sram_axi_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr_ok(inst_addr_ok), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_addr_ok(data_addr_ok),
        .data_size(data_size), .data_wstrb(data_wstrb), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .arid(arid), .araddr(araddr), .arsize(arsize), .arlen(arlen), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awsize(awsize), .awlen(awlen), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_table(input logic [31:0] a);
        case (a)
            32'hBFC00000: return 32'h3C1D0001;
            32'hBFC00004: return 32'h24080010;
            32'h80001000: return 32'h12345678;
            default:      return ~a;
        endcase
    endfunction

    // Slave: ready after *_lat cycles of valid, rvalid r_lat cycles after AR, B once AW and W both done.
    int ar_lat = 0, aw_lat = 0, w_lat = 0, r_lat = 0;

    initial begin : slave
        int ar_cnt, aw_cnt, w_cnt, r_cnt;
        bit r_pend, aw_got, w_got;
        bit ar_hs_p, r_hs_p, aw_hs_p, w_hs_p, b_hs_p;
        logic [31:0] ar_addr_p, r_addr_q;
        logic [3:0]  ar_id_p, r_id_q;
        arready = 0; rvalid = 0; rdata = '0; rid = '0;
        awready = 0; wready = 0; bvalid = 0;
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0;
        r_pend = 0; aw_got = 0; w_got = 0;
        ar_hs_p = 0; r_hs_p = 0; aw_hs_p = 0; w_hs_p = 0; b_hs_p = 0;
        ar_addr_p = '0; r_addr_q = '0; ar_id_p = '0; r_id_q = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
                ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0;
                r_pend = 0; aw_got = 0; w_got = 0;
                ar_hs_p = 0; r_hs_p = 0; aw_hs_p = 0; w_hs_p = 0; b_hs_p = 0;
            end else begin
                if (ar_hs_p) begin r_pend = 1; r_cnt = 0; r_addr_q = ar_addr_p; r_id_q = ar_id_p; end
                if (r_hs_p) rvalid = 0;
                if (aw_hs_p) aw_got = 1;
                if (w_hs_p) w_got = 1;
                if (b_hs_p) bvalid = 0;

                if (arvalid) begin arready = (ar_cnt >= ar_lat); ar_cnt++; end
                else begin arready = 0; ar_cnt = 0; end
                if (awvalid) begin awready = (aw_cnt >= aw_lat); aw_cnt++; end
                else begin awready = 0; aw_cnt = 0; end
                if (wvalid) begin wready = (w_cnt >= w_lat); w_cnt++; end
                else begin wready = 0; w_cnt = 0; end

                if (r_pend) begin
                    if (r_cnt >= r_lat) begin
                        rvalid = 1; rdata = rd_table(r_addr_q); rid = r_id_q; r_pend = 0;
                    end else begin
                        r_cnt++;
                    end
                end
                if (aw_got && w_got) begin bvalid = 1; aw_got = 0; w_got = 0; end

                ar_hs_p = arvalid && arready; ar_addr_p = araddr; ar_id_p = arid;
                r_hs_p  = rvalid && rready;
                aw_hs_p = awvalid && awready;
                w_hs_p  = wvalid && wready;
                b_hs_p  = bvalid && bready;
            end
        end
    end

    // Passive monitor, sampled on the falling edge.
    logic [38:0] ar_q[$];
    logic [38:0] prev_ar = '0;
    bit          ar_pend_prev = 0;
    int ar_unstable = 0, ar_wait_n = 0, aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0;
    int aw_hs_cyc = 0, w_hs_cyc = 0, b_cyc = 0;
    int inst_ok_n = 0, data_ok_n = 0, both_ok_n = 0, inst_ok_cyc = 0, data_ok_cyc = 0;
    logic [34:0] last_aw = '0;
    logic [35:0] last_w = '0;
    logic [31:0] last_inst_rdata = '0, last_data_rdata = '0;

    always @(negedge clk) begin
        if (reset) begin
            ar_pend_prev = 0;
        end else begin
            if (ar_pend_prev && (!arvalid || {arid, arsize, araddr} != prev_ar)) ar_unstable++;
            if (arvalid && !arready) ar_wait_n++;
            if (arvalid && arready) ar_q.push_back({arid, arsize, araddr});
            ar_pend_prev = arvalid && !arready;
            prev_ar = {arid, arsize, araddr};
            if (awvalid && awready) begin aw_hs_n++; aw_hs_cyc = cyc; last_aw = {awaddr, awsize}; end
            if (wvalid && wready) begin w_hs_n++; w_hs_cyc = cyc; last_w = {wdata, wstrb}; end
            if (bvalid && bready) begin b_hs_n++; b_cyc = cyc; end
            if (inst_data_ok) begin inst_ok_n++; inst_ok_cyc = cyc; last_inst_rdata = inst_rdata; end
            if (data_data_ok) begin data_ok_n++; data_ok_cyc = cyc; last_data_rdata = data_rdata; end
            if (inst_data_ok && data_data_ok) both_ok_n++;
        end
    end

    // Call at posedge+1 with the request already driven; drops it after acceptance.
    task automatic wait_accept(input bit is_inst, output int t);
        bit got;
        int n;
        got = 0; t = -1; n = 0;
        while (!got && n < 64) begin
            @(negedge clk);
            if (is_inst ? inst_addr_ok : data_addr_ok) begin got = 1; t = cyc; end
            @(posedge clk);
            #1;
            n++;
        end
        if (is_inst) inst_req = 0;
        else         data_req = 0;
        check("accept_timeout", {63'd0, got}, 64'd1);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t0, t, td, ti, tr, tw, s_inst, s_data, s_b, s_ar, s_unst, s_wait;
        reset = 1;
        inst_req = 0; inst_size = 2'd2; inst_addr = '0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = '0; data_addr = '0; data_wdata = '0;

        // Reset state and fixed AXI fields
        idle_cycles(3);
        @(negedge clk);
        check("rst_outs", {arvalid, rready, awvalid, wvalid, bready, inst_data_ok, data_data_ok,
                           inst_addr_ok, data_addr_ok}, 9'd0);
        check("rst_rdata", {inst_rdata, data_rdata}, 64'd0);
        check("rst_ar_fields", {arid, arsize, araddr}, 39'd0);
        check("tie_offs", {arlen, arburst, arlock, arcache, arprot, awid, awlen, awburst, awlock,
                           awcache, awprot, wid, wlast},
              {4'd0, 2'b01, 2'b00, 4'd0, 3'd0, 4'd1, 4'd0, 2'b01, 2'b00, 4'd0, 3'd0, 4'd1, 1'b1});
        @(posedge clk); #1;
        reset = 0;
        idle_cycles(2);

        // 1: zero-wait instruction read
        s_inst = inst_ok_n; s_data = data_ok_n;
        inst_req = 1; inst_addr = 32'hBFC00000; inst_size = 2'd2;
        t0 = cyc;
        wait_accept(1, t);
        check("t1_accept_cycle", t, t0);
        idle_cycles(6);
        check("t1_inst_ok_count", inst_ok_n - s_inst, 1);
        check("t1_inst_ok_cycle", inst_ok_cyc, t + 3);
        check("t1_inst_rdata", last_inst_rdata, 32'h3C1D0001);
        check("t1_ar_fields", ar_q[ar_q.size()-1], {4'd0, 3'd2, 32'hBFC00000});
        check("t1_no_data_ok", data_ok_n - s_data, 0);

        // 2: simultaneous inst and data reads, data wins
        s_ar = ar_q.size();
        data_req = 1; data_wr = 0; data_addr = 32'h80001000; data_size = 2'd1;
        inst_req = 1; inst_addr = 32'hBFC00004; inst_size = 2'd2;
        @(negedge clk);
        check("t2_data_accepted", data_addr_ok, 1);
        check("t2_inst_blocked", inst_addr_ok, 0);
        td = cyc;
        @(posedge clk); #1;
        data_req = 0;
        wait_accept(1, ti);
        check("t2_inst_accept_cycle", ti, td + 3);
        idle_cycles(6);
        check("t2_ar_count", ar_q.size() - s_ar, 2);
        check("t2_ar_first_data", ar_q[s_ar], {4'd1, 3'd1, 32'h80001000});
        check("t2_ar_second_inst", ar_q[s_ar+1], {4'd0, 3'd2, 32'hBFC00004});
        check("t2_data_ok_cycle", data_ok_cyc, td + 3);
        check("t2_data_rdata", last_data_rdata, 32'h12345678);
        check("t2_inst_ok_cycle", inst_ok_cyc, ti + 3);
        check("t2_inst_rdata", last_inst_rdata, 32'h24080010);

        // 3: write, W accepted 3 cycles before AW
        s_b = b_hs_n; s_data = data_ok_n;
        aw_lat = 3; w_lat = 0;
        data_req = 1; data_wr = 1; data_addr = 32'h80000010; data_size = 2'd2;
        data_wdata = 32'hDEADBEEF; data_wstrb = 4'hF;
        t0 = cyc;
        wait_accept(0, t);
        check("t3_accept_cycle", t, t0);
        idle_cycles(10);
        check("t3_w_before_aw", aw_hs_cyc - w_hs_cyc, 3);
        check("t3_b_count", b_hs_n - s_b, 1);
        check("t3_data_ok_count", data_ok_n - s_data, 1);
        check("t3_data_ok_after_b", data_ok_cyc, b_cyc + 1);
        check("t3_data_ok_cycle", data_ok_cyc, t + 6);
        check("t3_aw_fields", last_aw, {32'h80000010, 3'd2});
        check("t3_w_fields", last_w, {32'hDEADBEEF, 4'hF});
        aw_lat = 0;

        // 4: write blocked behind outstanding data read
        s_data = data_ok_n;
        data_req = 1; data_wr = 0; data_addr = 32'h80002000; data_size = 2'd2;
        wait_accept(0, tr);
        data_req = 1; data_wr = 1; data_addr = 32'h80000020; data_size = 2'd1;
        data_wdata = 32'hCAFEF00D; data_wstrb = 4'h3;
        wait_accept(0, tw);
        check("t4_write_accept_cycle", tw, tr + 3);
        idle_cycles(8);
        check("t4_data_ok_count", data_ok_n - s_data, 2);
        check("t4_read_rdata", data_rdata, 32'h7FFFDFFF);
        check("t4_write_ok_cycle", data_ok_cyc, tw + 3);
        check("t4_aw_fields", last_aw, {32'h80000020, 3'd1});
        check("t4_w_fields", last_w, {32'hCAFEF00D, 4'h3});

        // 5: arready held low for 5 cycles
        s_ar = ar_q.size(); s_unst = ar_unstable; s_wait = ar_wait_n;
        ar_lat = 5;
        inst_req = 1; inst_addr = 32'hBFC00000; inst_size = 2'd2;
        wait_accept(1, t);
        idle_cycles(12);
        check("t5_ar_stable", ar_unstable - s_unst, 0);
        check("t5_ar_wait_cycles", ar_wait_n - s_wait, 5);
        check("t5_single_ar", ar_q.size() - s_ar, 1);
        check("t5_inst_ok_cycle", inst_ok_cyc, t + 8);
        ar_lat = 0;

        // 6: reset while waiting for read data, then a fresh read
        s_inst = inst_ok_n;
        r_lat = 10;
        inst_req = 1; inst_addr = 32'hBFC00004;
        wait_accept(1, t);
        @(posedge clk); #1;
        check("t6_in_r_data", rready, 1);
        reset = 1;
        @(negedge clk);
        check("t6_rst_outs", {arvalid, rready, awvalid, wvalid, bready, inst_data_ok, data_data_ok,
                              inst_addr_ok, data_addr_ok}, 9'd0);
        check("t6_rst_rdata", {inst_rdata, data_rdata}, 64'd0);
        check("t6_rst_ar_fields", {arid, arsize, araddr}, 39'd0);
        @(posedge clk); #1;
        reset = 0; r_lat = 0;
        idle_cycles(1);
        inst_req = 1; inst_addr = 32'hBFC00000;
        t0 = cyc;
        wait_accept(1, t);
        check("t6_accept_cycle", t, t0);
        idle_cycles(6);
        check("t6_inst_ok_count", inst_ok_n - s_inst, 1);
        check("t6_inst_ok_cycle", inst_ok_cyc, t + 3);
        check("t6_inst_rdata", last_inst_rdata, 32'h3C1D0001);

        check("no_ok_collision", both_ok_n, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
